// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe.
// The upstream/downstream environment drives through the master modport;
// the immediate generator itself connects through the slave modport.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  // Input side: one instruction word plus its sideband tag
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;

  // Output side: decoded immediate, format code, illegal flag and tag
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Decodes the instruction at the input, stores the result in a main entry
// (which drives out_*) and, when downstream stalls, in a skid entry.
// in_ready is a flop output with no combinational path from out_ready.
//
// Optional feature: define IMM_GEN_PIPE_CSR_EN to decode SYSTEM opcode
// 1110011 (CSR immediate forms give fmt 7 and the zero-extended zimm).
// Without it, that opcode is flagged illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_pipe_if.slave  bus
);

  // Format codes presented on out_fmt
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_SH  = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_CSR = 3'd7
  } fmt_e;

  // One buffered decode result
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Shift funct3 values on OP_IMM (SLLI, SRLI/SRAI)
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Sign-extends a 32-bit pattern to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   drain;

  // Decode the incoming instruction into a complete entry
  always_comb begin
    // NOTE: every variable written here is given a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    dec         = '0;
    dec.valid   = 1'b1;
    dec.tag     = bus.in_tag;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    unique case (opcode)
      OP_LOAD, OP_JALR, OP_MISC_MEM: begin
        dec.fmt = FMT_I;
        dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
      end
      OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          // Only the shamt field is taken; funct7 bits above it are dropped
          dec.fmt = FMT_SH;
          if (XLEN == 64) dec.imm = XLEN'(inst[25:20]);
          else            dec.imm = XLEN'(inst[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = sext32({inst[31:12], 12'b0});
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0});
      end
      OP_REG: begin
        dec.fmt = FMT_R;
      end
`ifdef IMM_GEN_PIPE_CSR_EN
      OP_SYSTEM: begin
        // funct3[2] selects the CSR immediate forms; others carry no immediate
        if (funct3[2]) begin
          dec.fmt = FMT_CSR;
          dec.imm = XLEN'(inst[19:15]);
        end
      end
`else
      OP_SYSTEM: begin
        dec.illegal = 1'b1;
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Handshake qualifiers for this edge
  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_q.valid & bus.out_ready;

  // Next state of the main/skid pair; FIFO order is main before skid
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (drain) begin
      if (skid_q.valid) begin
        // FULL: skid advances into main; in_ready_q blocks any accept here
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      if (main_q.valid) skid_d = dec;
      else              main_d = dec;
    end
    // Ready for the next cycle whenever the skid slot will be free
    in_ready_d = ~skid_d.valid;
  end

  // Storage and ready flop; reset discards both entries at once
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the entry payloads are reset as well as the valid bits, because
    // out_imm/out_fmt/out_illegal/out_tag are required to read 0 in reset.
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before the edge, independent of statement order.
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_q.valid;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_tag     = main_q.tag;

endmodule
